// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame FSM encoding,
// data width and the elaboration-time baud divisor.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Rounded clock cycles per bit, floored at 2 so the tick can never stick high.
  function automatic int baud_div(input int clk_freq, input int baud);
    int div;
    div = (clk_freq + baud / 2) / baud;
    if (div < 2) div = 2;
    return div;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Handshake between the upstream FIFO sequencer (master) and the UART
// transmitter (slave), plus the serial line itself.
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                      TxD_start;
  logic [UART_DATA_BITS-1:0] TxD_data;
  logic                      TxD_busy;
  logic                      TxD;

  modport master (
    output TxD_start,
    output TxD_data,
    input  TxD_busy,
    input  TxD
  );

  modport slave (
    input  TxD_start,
    input  TxD_data,
    output TxD_busy,
    output TxD
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 and pulses o_tick for one cycle at DIV-1.
// i_clr pins the count at 0 so the first bit after a start is a full period.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter: one frame per accepted TxD_start, all outputs
// registered, busy held from the acceptance edge through the last stop bit.
//
// state    | meaning
// ST_IDLE  | line high, waiting for TxD_start
// ST_START | start bit (0) for one bit period
// ST_DATA  | data bits LSB first, r_bit_idx = bit being sent
// ST_STOP  | stop bit(s) high, r_bit_idx = stop bit being sent
import uart_pkg::*;

module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_serializer_if.slave bus
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int SB  = (STOP_BITS == 2) ? 2 : 1;

  uart_state_t               r_state;
  uart_state_t               w_state_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic [2:0]                r_bit_idx;
  logic [2:0]                w_bit_idx_nxt;
  logic                      r_txd;
  logic                      w_txd_nxt;
  logic                      r_busy;
  logic                      w_busy_nxt;
  logic                      w_tick;
  logic                      w_baud_clr;

  assign w_baud_clr   = (r_state == ST_IDLE);
  assign bus.TxD      = r_txd;
  assign bus.TxD_busy = r_busy;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_baud_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_txd_nxt     = r_txd;
    w_busy_nxt    = r_busy;

    unique case (r_state)
      ST_IDLE: begin
        w_txd_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        if (bus.TxD_start) begin
          w_shift_nxt   = bus.TxD_data;
          w_bit_idx_nxt = '0;
          w_txd_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = ST_START;
        end
      end

      ST_START: begin
        if (w_tick) begin
          w_bit_idx_nxt = '0;
          w_txd_nxt     = r_shift[0];
          w_state_nxt   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
            w_bit_idx_nxt = '0;
            w_txd_nxt     = 1'b1;
            w_state_nxt   = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_txd_nxt     = w_shift_nxt[0];
          end
        end
      end

      ST_STOP: begin
        // Busy drops on the same edge the final stop period ends.
        if (w_tick) begin
          if (r_bit_idx == 3'(SB - 1)) begin
            w_bit_idx_nxt = '0;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
